// File: rtl/i2s_rx_10xe_core_if.sv
// AXI-Stream bundle carrying received audio words and their channel id.
interface i2s_rx_10xe_core_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tid;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tid, output tvalid, input tready);
  modport slave  (input tdata, input tid, input tvalid, output tready);
endinterface

// File: rtl/i2s_rx_10xe_core.sv
// I2S receiver: synchronises an external I2S stream, assembles L/R words into a FIFO and streams
// them out over AXI-Stream. Define I2S_RX_LEFT_JUST_EN for left-justified framing.
module i2s_rx_10xe_core #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        aud_mclk,
  input  logic                        aud_mrst,
  input  logic                        rx_en,
  input  logic                        sclk_in,
  input  logic                        lrclk_in,
  input  logic                        sdata_0_in,
  i2s_rx_10xe_core_if.master          m_axis,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        irq,
  input  logic                        irq_clr
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MsbOne = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StSync, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, lr_sync_q, lr_sync_d, sd_sync_q, sd_sync_d;
  logic                   sclk_d1_q;
  logic                   sample, lr_s, sd_s;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_ins, mask;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  room, lr_chg;
  logic                  lr_prev_q, lr_prev_d, have_prev_q, have_prev_d;
  logic                  commit_q, commit_d, ctid_q, ctid_d;
  logic [DATA_WIDTH-1:0] cdata_q, cdata_d;

  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  irq_q, irq_d;
  logic                  valid, full, pop, push_ok, ovf;
  logic [DATA_WIDTH:0]   head;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk_in};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sdata_0_in};
    sample      = sclk_sync_q[SYNC_STAGES-1] & ~sclk_d1_q;
    lr_s        = lr_sync_q[SYNC_STAGES-1];
    sd_s        = sd_sync_q[SYNC_STAGES-1];
  end

  // Shift reg is kept left-aligned, so a short word needs no realignment at commit.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    lr_prev_d   = lr_prev_q;
    have_prev_d = have_prev_q;
    commit_d    = 1'b0;
    cdata_d     = cdata_q;
    ctid_d      = ctid_q;
    mask        = MsbOne >> cnt_q;
    room        = cnt_q < CntW'(DATA_WIDTH);
    sr_ins      = (room && sd_s) ? (sr_q | mask) : sr_q;
    cnt_inc     = room ? cnt_q + CntW'(1) : cnt_q;
    lr_chg      = have_prev_q && (lr_s != lr_prev_q);
    if (sample) begin
      lr_prev_d   = lr_s;
      have_prev_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        sr_d        = '0;
        cnt_d       = '0;
        have_prev_d = 1'b0;
        state_d     = StSync;
      end
      StSync: begin
        if (sample && lr_chg) begin
          state_d = StShift;
`ifdef I2S_RX_LEFT_JUST_EN
          sr_d    = sd_s ? MsbOne : '0;
          cnt_d   = CntW'(1);
`else
          sr_d    = '0;
          cnt_d   = '0;
`endif
        end
      end
      StShift: begin
        if (sample && lr_chg) begin
          commit_d = 1'b1;
          ctid_d   = lr_prev_q;
`ifdef I2S_RX_LEFT_JUST_EN
          cdata_d  = sr_q;
          sr_d     = sd_s ? MsbOne : '0;
          cnt_d    = CntW'(1);
`else
          cdata_d  = sr_ins;
          sr_d     = '0;
          cnt_d    = '0;
`endif
        end else if (sample) begin
          sr_d  = sr_ins;
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rx_en) begin
      state_d     = StIdle;
      sr_d        = '0;
      cnt_d       = '0;
      have_prev_d = 1'b0;
      commit_d    = 1'b0;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    valid    = level_q != '0;
    full     = level_q == (AW+1)'(FIFO_DEPTH);
    pop      = valid & m_axis.tready;
    push_ok  = commit_q & (~full | pop);
    ovf      = commit_q & full & ~pop;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (ovf)     irq_d = 1'b1;
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    m_axis.tvalid = valid;
    m_axis.tdata  = valid ? head[DATA_WIDTH-1:0] : '0;
    m_axis.tid    = valid ? head[DATA_WIDTH] : 1'b0;
    fifo_level    = level_q;
    irq           = irq_q;
  end

  always_ff @(posedge aud_mclk or negedge aud_mrst) begin
    if (!aud_mrst) begin
      sclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_d1_q   <= 1'b0;
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      lr_prev_q   <= 1'b0;
      have_prev_q <= 1'b0;
      commit_q    <= 1'b0;
      cdata_q     <= '0;
      ctid_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      sclk_d1_q   <= sclk_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      lr_prev_q   <= lr_prev_d;
      have_prev_q <= have_prev_d;
      commit_q    <= commit_d;
      cdata_q     <= cdata_d;
      ctid_q      <= ctid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      irq_q       <= irq_d;
    end
  end

  // Storage needs no reset: tvalid masks stale entries.
  always_ff @(posedge aud_mclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {ctid_q, cdata_q};
  end

endmodule
